// File: rtl/mmu_feeder.sv
// mmu_feeder: front end of the weight-stationary systolic array.
// Loads one weight matrix, bottom row first, and then streams activation
// vectors into the array through a triangular skew, where row i lags
// row 0 by i cycles. It also raises res_valid in the cycle that
// acc_out_final carries the column-0 result of an accepted vector.
module mmu_feeder #(
    parameter int bit_width = 8,
    parameter int size      = 16,
    parameter int res_lat   = 2 * size
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [size-1:0][bit_width-1:0]  wt_in,
    input  logic                            wt_valid,
    output logic                            wt_ready,
    input  logic [size-1:0][bit_width-1:0]  act_in,
    input  logic                            act_valid,
    input  logic                            act_last,
    output logic                            act_ready,
    output logic                            control,
    output logic [size-1:0][bit_width-1:0]  wt_arr,
    output logic [size-1:0][bit_width-1:0]  data_arr,
    output logic                            res_valid,
    output logic                            busy,
    output logic                            done
);

    localparam int cnt_w   = $clog2(size + 1);
    localparam int drain_w = $clog2(res_lat + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WT,
        STREAM,
        DRAIN
    } state_t;

    state_t                         state;
    state_t                         next_state;
    logic [cnt_w-1:0]               wt_cnt;
    logic [drain_w-1:0]             drain_cnt;
    logic                           wt_accept;
    logic                           act_accept;
    logic [size-1:0][bit_width-1:0] entry;
    logic [res_lat-1:0]             res_pipe;

    // The ready outputs are gated by reset so that both read low while
    // reset is held, even though the state register then reads IDLE.
    assign wt_ready   = reset && (state == IDLE || state == LOAD_WT);
    assign act_ready  = reset && (state == STREAM);
    assign wt_accept  = wt_ready && wt_valid;
    assign act_accept = act_ready && act_valid;
    assign busy       = (state != IDLE);
    assign res_valid  = res_pipe[res_lat-1];

    // Bubble cycles and non-stream states push zeros so the skew timing of
    // the data already in flight does not change.
    assign entry = act_accept ? act_in : '0;

    // Next-state logic and the combinational weight pass-through.
    always_comb begin
        next_state = state;
        control    = 1'b0;
        wt_arr     = '0;
        done       = 1'b0;
        case (state)
            IDLE, LOAD_WT: begin
                if (wt_accept) begin
                    control    = 1'b1;
                    wt_arr     = wt_in;
                    next_state = (wt_cnt == cnt_w'(size - 1)) ? STREAM : LOAD_WT;
                end
            end
            STREAM: begin
                if (act_accept && act_last) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == drain_w'(res_lat - 1)) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Count accepted weight rows. The counter wraps to zero on the last row,
    // so it always reads zero again by the time the next batch starts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wt_cnt <= '0;
        end else if (wt_accept) begin
            wt_cnt <= (wt_cnt == cnt_w'(size - 1)) ? '0 : wt_cnt + cnt_w'(1);
        end
    end

    // Count drain cycles. The counter rests at zero outside DRAIN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_cnt <= '0;
        end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + drain_w'(1);
        end else begin
            drain_cnt <= '0;
        end
    end

    // Result-valid pipe. It shifts every cycle in every state so that no
    // pending strobe is lost across a state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_pipe <= '0;
        end else begin
            res_pipe <= {res_pipe[res_lat-2:0], act_accept};
        end
    end

    // Row 0 reaches the array with no delay.
    assign data_arr[0] = entry[0];

    generate
        for (genvar r = 1; r < size; r++) begin : g_skew
            logic [bit_width-1:0] dly [r];

            // Delay row r by r cycles through its own shift line.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < r; k++) begin
                        dly[k] <= '0;
                    end
                end else begin
                    dly[0] <= entry[r];
                    for (int k = 1; k < r; k++) begin
                        dly[k] <= dly[k-1];
                    end
                end
            end

            assign data_arr[r] = dly[r-1];
        end
    endgenerate

endmodule

// File: tb/tb_mmu_feeder.sv
// tb_mmu_feeder: directed and randomized checks of mmu_feeder at size=4.
// The reference model keeps a history of the vectors that entered the array
// and of the acceptance flags, and derives every output from those.
module tb_mmu_feeder;

    localparam int BW = 8;
    localparam int SZ = 4;
    localparam int RL = 8;

    typedef logic [SZ-1:0][BW-1:0] vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    vec_t wt_in = '0;
    logic wt_valid = 1'b0;
    logic wt_ready;
    vec_t act_in = '0;
    logic act_valid = 1'b0;
    logic act_last = 1'b0;
    logic act_ready;
    logic control;
    vec_t wt_arr;
    vec_t data_arr;
    logic res_valid;
    logic busy;
    logic done;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: batch phase 0=idle, 1=loading, 2=streaming, 3=draining.
    int   phase;
    int   wcount;
    int   dcount;
    vec_t hist[$];
    bit   acc_q[$];
    int   model_done = 0;
    int   dut_done = 0;

    mmu_feeder #(.bit_width(BW), .size(SZ), .res_lat(RL)) dut (
        .clk       (clk),
        .reset     (reset),
        .wt_in     (wt_in),
        .wt_valid  (wt_valid),
        .wt_ready  (wt_ready),
        .act_in    (act_in),
        .act_valid (act_valid),
        .act_last  (act_last),
        .act_ready (act_ready),
        .control   (control),
        .wt_arr    (wt_arr),
        .data_arr  (data_arr),
        .res_valid (res_valid),
        .busy      (busy),
        .done      (done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        phase  = 0;
        wcount = 0;
        dcount = 0;
        hist   = {};
        acc_q  = {};
        for (int i = 0; i < SZ; i++) hist.push_back('0);
        for (int i = 0; i < RL; i++) acc_q.push_back(1'b0);
    endtask

    // Drive one cycle of inputs, check every output against the model, then
    // advance the model across the clock edge.
    task automatic applyStimulus(input logic wv, input vec_t wd, input logic av,
                                 input vec_t ad, input logic al);
        bit   acc_w;
        bit   acc_a;
        bit   exp_done;
        vec_t exp_data;
        @(negedge clk);
        wt_valid  = wv;
        wt_in     = wd;
        act_valid = av;
        act_in    = ad;
        act_last  = al;
        #1;
        acc_w = reset && (phase <= 1) && wv;
        acc_a = reset && (phase == 2) && av;
        hist.push_front(acc_a ? ad : vec_t'('0));
        for (int i = 0; i < SZ; i++) exp_data[i] = hist[i][i];
        void'(hist.pop_back());
        exp_done = (phase == 3) && (dcount == RL - 1);
        checkOutput("wt_ready", wt_ready, reset && (phase <= 1));
        checkOutput("act_ready", act_ready, reset && (phase == 2));
        checkOutput("control", control, acc_w);
        checkOutput("wt_arr", wt_arr, acc_w ? wd : vec_t'('0));
        checkOutput("data_arr", data_arr, exp_data);
        checkOutput("res_valid", res_valid, acc_q[RL-1]);
        checkOutput("busy", busy, phase != 0);
        checkOutput("done", done, exp_done);
        if (done === 1'b1) dut_done++;
        if (exp_done) model_done++;
        @(posedge clk);
        if (!reset) begin
            modelReset();
        end else begin
            acc_q.push_front(acc_a);
            void'(acc_q.pop_back());
            case (phase)
                0, 1: if (acc_w) begin
                    wcount++;
                    if (wcount == SZ) begin
                        phase  = 2;
                        wcount = 0;
                    end else begin
                        phase = 1;
                    end
                end
                2: if (acc_a && al) begin
                    phase  = 3;
                    dcount = 0;
                end
                default: if (dcount == RL - 1) phase = 0; else dcount++;
            endcase
        end
    endtask

    function automatic vec_t mk(input int base);
        vec_t v;
        for (int j = 0; j < SZ; j++) v[j] = BW'(base * 16 + j);
        return v;
    endfunction

    function automatic vec_t seq(input int first);
        vec_t v;
        for (int j = 0; j < SZ; j++) v[j] = BW'(first + j);
        return v;
    endfunction

    function automatic vec_t rnd();
        vec_t v;
        for (int j = 0; j < SZ; j++) v[j] = BW'($urandom);
        return v;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic loadRows();
        for (int r = SZ; r >= 1; r--) applyStimulus(1'b1, mk(r), 1'b0, '0, 1'b0);
    endtask

    // Directed scenarios first, then randomized batches.
    initial begin
        modelReset();
        // Reset state, with handshakes offered and ignored.
        applyStimulus(1'b1, mk(9), 1'b1, seq(9), 1'b1);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Back-to-back weight load, then two vectors with the last marked.
        loadRows();
        applyStimulus(1'b1, mk(7), 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, seq(1), 1'b0);
        applyStimulus(1'b1, mk(7), 1'b1, seq(5), 1'b1);
        idle(RL + 2);

        // Weight stall on the second row, then a bubble between two vectors.
        applyStimulus(1'b1, mk(4), 1'b0, '0, 1'b0);
        applyStimulus(1'b0, mk(5), 1'b0, '0, 1'b0);
        for (int r = 3; r >= 1; r--) applyStimulus(1'b1, mk(r), 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, seq(10), 1'b0);
        applyStimulus(1'b0, '0, 1'b0, seq(99), 1'b1);
        applyStimulus(1'b0, '0, 1'b1, seq(20), 1'b1);
        idle(RL + 1);
        applyStimulus(1'b1, mk(2), 1'b0, '0, 1'b0);
        checkOutput("done_count", dut_done, model_done);

        // Reset asserted between edges in the middle of streaming.
        loadRows();
        applyStimulus(1'b0, '0, 1'b1, seq(30), 1'b0);
        applyStimulus(1'b0, '0, 1'b1, seq(40), 1'b0);
        @(negedge clk);
        act_valid = 1'b1;
        act_in    = seq(50);
        #2 reset = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_act_ready", act_ready, 1'b0);
        checkOutput("rst_data_arr", data_arr, vec_t'('0));
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_wt_ready", wt_ready, 1'b0);
        idle(3);
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        loadRows();
        applyStimulus(1'b0, '0, 1'b1, seq(60), 1'b1);
        idle(RL + 1);
        checkOutput("done_count_rst", dut_done, model_done);

        // Randomized batches with random stalls, bubbles and last markers.
        for (int c = 0; c < 600; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, rnd(),
                          $urandom_range(0, 3) != 0, rnd(),
                          $urandom_range(0, 4) == 0);
        end
        checkOutput("done_count_rand", dut_done, model_done);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmu_feeder.md
Name: mmu_feeder

Overview:
- Upstream stage of the weight-stationary systolic array top (MMU).
- Sequences weight preload, then accepts activation vectors over a valid/ready handshake and skews them so row i lags row 0 by i cycles.
- Drives the array's control, data_arr and wt_arr inputs, and emits a result-valid strobe aligned to acc_out_final for downstream capture.

Parameters:
- bit_width, 8, width of each weight/activation element
- size, 16, array dimension (rows = columns = size)
- res_lat, 2*size, cycles from an activation vector's acceptance to its column-0 result on acc_out_final

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wt_in  in  [bit_width-1:0] x size  one weight row vector
- wt_valid  in  1  wt_in valid
- wt_ready  out  1  feeder accepts wt_in this cycle
- act_in  in  [bit_width-1:0] x size  one activation vector (element i goes to array row i)
- act_valid  in  1  act_in valid
- act_last  in  1  marks final activation vector of the batch
- act_ready  out  1  feeder accepts act_in this cycle
- control  out  1  weight-shift enable to array
- wt_arr  out  [bit_width-1:0] x size  weights to array top row
- data_arr  out  [bit_width-1:0] x size  skewed activations to array rows
- res_valid  out  1  acc_out_final holds column-0 result of an accepted vector
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of batch

Behaviour:
- Reset (async, reset=0): state=IDLE, wt_cnt=0, drain_cnt=0, all skew delay lines and res_valid pipe cleared; control=0, wt_arr=0, data_arr=0, res_valid=0, busy=0, done=0, wt_ready=0, act_ready=0. Reset mid-batch aborts with no done pulse.
- States: IDLE, LOAD_WT, STREAM, DRAIN.
- IDLE: wt_ready=1. First accepted wt_in moves to LOAD_WT with wt_cnt=1. act_ready=0.
- LOAD_WT: wt_ready=1. Weight rows are presented bottom row first (row size-1 first, row 0 last).
  - Each accepted vector: wt_arr=wt_in and control=1 in the same cycle (combinational pass-through), wt_cnt++.
  - Stall cycles (wt_valid=0): control=0 and wt_arr=0, so the array weight shift freezes.
  - After the size-th acceptance: go to STREAM next cycle.
  - data_arr=0 throughout.
- STREAM: act_ready=1, wt_ready=0, control=0.
  - Accepted vector is written into the skew lines. Row i passes through i registers: row 0 combinational, row size-1 delayed size-1 cycles.
  - Bubble cycle (act_valid=0): a zero vector enters the skew lines; skew timing is preserved.
  - An accepted vector with act_last=1 moves to DRAIN next cycle, drain_cnt=0.
- DRAIN: act_ready=0. Zeros enter the skew lines. drain_cnt++ each cycle.
  - At drain_cnt==res_lat-1: done=1 for that cycle, then IDLE.
  - This guarantees every pending res_valid has fired.
- res_valid: res_lat-deep shift register. Input is 1 on act accept, else 0. It runs in every state and is cleared only by reset.
- No arithmetic is performed here. Elements pass unmodified at bit_width; no sign handling.
- act_valid or wt_valid in a state whose ready is low is ignored: not accepted, no state change.
- act_last with act_valid=0 is ignored.

Test Plan:
- Use size=4, res_lat=8. Load rows 4,3,2,1 on consecutive cycles -> control=1 for exactly 4 cycles; wt_arr=4,3,2,1; STREAM entered on the 5th cycle.
- Weight load with wt_valid low on the 2nd cycle -> control=0 and wt_arr=0 that cycle; 4 total control pulses; still enters STREAM.
- Stream act {1,2,3,4} then {5,6,7,8}(last) -> data_arr[0]=1,5; data_arr[3]=4 appears 3 cycles after acceptance; res_valid pulses exactly 8 and 9 cycles after the two acceptances.
- Stream with one bubble between two vectors -> zero inserted on every row at the correct skewed cycle; res_valid shows a 1-cycle gap.
- Last vector accepted -> DRAIN lasts 8 cycles, done pulses once, busy drops the cycle after done, next wt_in accepted.
- Assert reset during STREAM -> all outputs 0 immediately (async); no done pulse; IDLE after release, with a clean reload.
